// File: rtl/defines_fetch.sv
// defines_fetch: shared constants and entry type for the instruction-fetch front end
package defines_fetch;
    localparam int IROM_LAT_MAX = 2;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous prefetch FIFO of fetch entries with push/pop/flush and occupancy
module fetch_queue
    import defines_fetch::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     cpu_clk,
    input  logic                     cpu_rst,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge cpu_clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end
    // An empty queue presents zeros rather than stale RAM contents
    assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: IROM fetch front end with latency slot pipe, prefetch queue and redirect flush
module cpu_fetch_unit
    import defines_fetch::*;
#(
    parameter int          ADDR_W   = 14,
    parameter int          DEPTH    = 4,
    parameter int          IROM_LAT = 1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     cpu_clk,
    input  logic                     cpu_rst,
    output logic [ADDR_W-1:0]        inst_addr,
    input  logic [31:0]              inst,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_pc4,
    output logic [$clog2(DEPTH):0]   q_count
);
    logic [31:0] fetch_pc;
    logic [IROM_LAT-1:0] slot_v;
    logic [31:0] slot_pc [IROM_LAT];
    logic [31:0] inflight;
    logic issue, pop;
    fetch_entry_t head;
    always_comb begin
        inflight = '0;
        for (int i = 0; i < IROM_LAT; i++) inflight = inflight + 32'(slot_v[i]);
    end
    // Reservation counts in-flight reads so every response has a queue slot waiting
    assign issue     = (32'(q_count) + inflight) < 32'(DEPTH);
    assign pop       = out_valid && out_ready;
    assign inst_addr = fetch_pc[ADDR_W+1:2];
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) fetch_pc <= RESET_PC;
        else if (redirect_valid) fetch_pc <= redirect_pc & ~32'd3;
        else if (issue) fetch_pc <= fetch_pc + 32'd4;
    end
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst || redirect_valid) begin
            slot_v <= '0;
        end else begin
            slot_v[0] <= issue;
            for (int i = 1; i < IROM_LAT; i++) slot_v[i] <= slot_v[i-1];
        end
    end
    always_ff @(posedge cpu_clk) begin
        slot_pc[0] <= fetch_pc;
        for (int i = 1; i < IROM_LAT; i++) slot_pc[i] <= slot_pc[i-1];
    end
    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .push       (slot_v[IROM_LAT-1]),
        .push_entry ('{pc: slot_pc[IROM_LAT-1], inst: inst}),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (q_count)
    );
    assign out_valid = q_count != '0;
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;
    assign out_pc4   = out_valid ? head.pc + 32'd4 : '0;
endmodule
